// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a prefetch FIFO.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
//   state   | meaning
//   S_IDLE  | no request in flight; waits for FIFO space and !halted
//   S_REQ   | mem_req held until mem_gnt (suppressed while a stale reply is pending)
//   S_WAIT  | request accepted, waiting for mem_rvalid
//   S_FAULT | misaligned redirect seen; terminal until reset
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 16,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect,
    input  logic [63:0]       pc,
    input  logic              halted,
    output logic [31:0]       instruction,
    output logic [63:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic              fault
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;

    state_t        state, state_next;
    logic [63:0]   fa, fa_issued;
    logic          discard, discard_redir;
    logic [31:0]   fifo_data [DEPTH];
    logic [63:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_next;
    logic          take_redirect, misaligned, grant, push, pop;

    assign instr_valid = (count != '0);
    assign instruction = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign mem_req     = (state == S_REQ) && !discard;
    assign mem_addr    = mem_req ? fa[ADDR_W-1:0] : '0;

    always_comb begin
        take_redirect = redirect && (state != S_FAULT);
        misaligned    = (pc[1:0] != 2'b00);
        grant         = mem_req && mem_gnt;
        push          = mem_rvalid && (state == S_WAIT) && !discard && !redirect;
        pop           = instr_valid && instr_ready && !redirect;
        count_next    = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
        // A reply still owed by memory after the redirect edge must be swallowed.
        discard_redir = (discard && !mem_rvalid) || ((state == S_WAIT) && !mem_rvalid) || grant;

        state_next = state;
        case (state)
            S_IDLE:  if (!halted && (count < FULL)) state_next = S_REQ;
            S_REQ:   if (grant) state_next = S_WAIT;
            S_WAIT:  if (mem_rvalid)
                         state_next = (!halted && (count_next < FULL)) ? S_REQ : S_IDLE;
            default: state_next = S_FAULT;
        endcase
        if (take_redirect)
            state_next = misaligned ? S_FAULT : (halted ? S_IDLE : S_REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fa        <= RESET_PC;
            fa_issued <= '0;
            discard   <= 1'b0;
            fault     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            state <= state_next;
            if (take_redirect) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                discard <= discard_redir;
                if (misaligned)
                    fault <= 1'b1;
                else
                    fa <= pc;
            end else begin
                if (grant) begin
                    fa        <= fa + 64'd4;
                    fa_issued <= fa;
                end
                if (mem_rvalid && discard)
                    discard <= 1'b0;
                if (push) begin
                    fifo_data[wr_ptr] <= mem_rdata;
                    fifo_pc[wr_ptr]   <= fa_issued;
                    wr_ptr            <= wr_ptr + PTR_ONE;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                count <= count_next;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (redirect) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (instr_ready && !instr_valid && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
